// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl : EX-stage hazard controller for the 5-stage pipeline.
//   - ID-stage forwarding selects, registered into EX (FwdA/FwdB)
//   - load-use bubble injection, branch/jump flush, multi-cycle EX freeze
// Optional macro HAZARD_STATS_EN adds saturating stall/flush/freeze counters.
module ex_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] ID_rs,
   input  logic [REG_AW-1:0] ID_rt,
   input  logic              ID_uses_rs,
   input  logic              ID_uses_rt,
   input  logic              ID_Jump,
   input  logic [REG_AW-1:0] EX_rd,
   input  logic              EX_RegWrite,
   input  logic              EX_MemRead,
   input  logic [REG_AW-1:0] MEM_rd,
   input  logic              MEM_RegWrite,
   input  logic              EX_Branch_EN,
   input  logic              ex_busy,
   output logic              PC_Write,
   output logic              IF_ID_Write,
   output logic              IF_ID_Flush,
   output logic              ID_EX_Flush,
   output logic              Pipe_Freeze,
   output logic [1:0]        FwdA,
   output logic [1:0]        FwdB
`ifdef HAZARD_STATS_EN
   ,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt,
   output logic [STAT_W-1:0] freeze_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   state_t      state_reg, state_next;
   logic [1:0]  fwd_a_reg, fwd_b_reg;
   logic [1:0]  fwd_a_next, fwd_b_next;

   // Per-operand view of the ID instruction: index 0 is rs, index 1 is rt.
   logic [REG_AW-1:0] id_src [2];
   logic [1:0]        id_use;
   logic [1:0]        ex_hit;
   logic [1:0]        mem_hit;
   logic [1:0]        ld_hit;
   logic [1:0]        sel_next [2];

   logic ex_live;
   logic mem_live;
   logic ld_live;
   logic load_use;
   logic hold_cyc;
   logic branch_cyc;
   logic stall_cyc;
   logic jump_cyc;

   assign id_src[0] = ID_rs;
   assign id_src[1] = ID_rt;
   assign id_use    = {ID_uses_rt, ID_uses_rs};

   // Register 0 is hardwired, so a write to it never produces a value to forward.
   assign ex_live  = EX_RegWrite  & (EX_rd  != '0);
   assign mem_live = MEM_RegWrite & (MEM_rd != '0);
   assign ld_live  = EX_MemRead   & (EX_rd  != '0);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_operand
         assign ex_hit[gi]  = id_use[gi] & ex_live  & (EX_rd  == id_src[gi]);
         assign mem_hit[gi] = id_use[gi] & mem_live & (MEM_rd == id_src[gi]);
         assign ld_hit[gi]  = id_use[gi] & ld_live  & (EX_rd  == id_src[gi]);
         // The younger producer (EX) wins over the older one (MEM).
         assign sel_next[gi] = ex_hit[gi]  ? FWD_MEM :
                               mem_hit[gi] ? FWD_WB  : FWD_RF;
      end
   endgenerate

   assign load_use = |ld_hit;

   // Cycle classification in priority order: freeze, branch, load-use, jump.
   assign hold_cyc   = ex_busy;
   assign branch_cyc = ~ex_busy & EX_Branch_EN;
   assign stall_cyc  = ~ex_busy & ~EX_Branch_EN & load_use;
   assign jump_cyc   = ~ex_busy & ~EX_Branch_EN & ~load_use & ID_Jump;

   // Control decode: outputs act in the same cycle; only Fwd and state are registered.
   always_comb begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      Pipe_Freeze = 1'b0;
      fwd_a_next  = sel_next[0];
      fwd_b_next  = sel_next[1];
      state_next  = RUN;
      if (!reset) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
         fwd_a_next  = FWD_RF;
         fwd_b_next  = FWD_RF;
      end else begin
         case (state_reg)
            // Every legal state re-evaluates the ID instruction as soon as ex_busy is low.
            RUN, STALL, HOLD: begin
               if (hold_cyc) begin
                  Pipe_Freeze = 1'b1;
                  PC_Write    = 1'b0;
                  IF_ID_Write = 1'b0;
                  fwd_a_next  = fwd_a_reg;
                  fwd_b_next  = fwd_b_reg;
                  state_next  = HOLD;
               end else if (branch_cyc) begin
                  IF_ID_Flush = 1'b1;
                  ID_EX_Flush = 1'b1;
                  fwd_a_next  = FWD_RF;
                  fwd_b_next  = FWD_RF;
               end else if (stall_cyc) begin
                  PC_Write    = 1'b0;
                  IF_ID_Write = 1'b0;
                  ID_EX_Flush = 1'b1;
                  fwd_a_next  = FWD_RF;
                  fwd_b_next  = FWD_RF;
                  state_next  = STALL;
               end else if (jump_cyc) begin
                  IF_ID_Flush = 1'b1;
               end
            end
            // Unused encoding: behave as a normal cycle and recover to RUN.
            default: begin
               state_next = RUN;
            end
         endcase
      end
   end

   // State and forwarding-select registers, advanced together with ID/EX.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= RUN;
         fwd_a_reg <= FWD_RF;
         fwd_b_reg <= FWD_RF;
      end else begin
         state_reg <= state_next;
         fwd_a_reg <= fwd_a_next;
         fwd_b_reg <= fwd_b_next;
      end
   end

   assign FwdA = fwd_a_reg;
   assign FwdB = fwd_b_reg;

`ifdef HAZARD_STATS_EN
   localparam logic [STAT_W-1:0] STAT_MAX = '1;
   localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

   logic [STAT_W-1:0] stall_cnt_reg, flush_cnt_reg, freeze_cnt_reg;

   // Event counters; each sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg  <= '0;
         flush_cnt_reg  <= '0;
         freeze_cnt_reg <= '0;
      end else begin
         if (stall_cyc && (stall_cnt_reg != STAT_MAX))
            stall_cnt_reg <= stall_cnt_reg + STAT_ONE;
         if (branch_cyc && (flush_cnt_reg != STAT_MAX))
            flush_cnt_reg <= flush_cnt_reg + STAT_ONE;
         if (hold_cyc && (freeze_cnt_reg != STAT_MAX))
            freeze_cnt_reg <= freeze_cnt_reg + STAT_ONE;
      end
   end

   assign stall_cnt  = stall_cnt_reg;
   assign flush_cnt  = flush_cnt_reg;
   assign freeze_cnt = freeze_cnt_reg;
`else
   // Counters are not built; STAT_W only sizes them, and a zero width would be meaningless.
   if (STAT_W < 1) begin : g_stat_w_unused
   end
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl : directed + randomized check of ex_hazard_ctrl against a
// cycle-level behavioural model of the hazard rules.
module tb_ex_hazard_ctrl;
   localparam int AW = 5;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] ID_rs = '0, ID_rt = '0, EX_rd = '0, MEM_rd = '0;
   logic          ID_uses_rs = 0, ID_uses_rt = 0, ID_Jump = 0;
   logic          EX_RegWrite = 0, EX_MemRead = 0, MEM_RegWrite = 0;
   logic          EX_Branch_EN = 0, ex_busy = 0;
   logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze;
   logic [1:0]    FwdA, FwdB;
`ifdef HAZARD_STATS_EN
   logic [SW-1:0] stall_cnt, flush_cnt, freeze_cnt;
`endif

   ex_hazard_ctrl #(.REG_AW(AW), .STAT_W(SW)) dut (
      .clk(clk), .reset(reset),
      .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rs(ID_uses_rs), .ID_uses_rt(ID_uses_rt),
      .ID_Jump(ID_Jump), .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
      .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite), .EX_Branch_EN(EX_Branch_EN),
      .ex_busy(ex_busy), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
      .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .Pipe_Freeze(Pipe_Freeze),
      .FwdA(FwdA), .FwdB(FwdB)
`ifdef HAZARD_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: the operand selects EX currently holds, plus event tallies.
   logic [1:0] m_fwd_a = 2'b00, m_fwd_b = 2'b00;
   int m_stall = 0, m_flush = 0, m_freeze = 0;
   int stat_max = (1 << SW) - 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Which older instruction, if any, supplies this operand.
   function automatic logic [1:0] want_src(input logic [AW-1:0] src, input logic used);
      if (used && EX_RegWrite && EX_rd != 0 && EX_rd == src) return 2'b01;
      if (used && MEM_RegWrite && MEM_rd != 0 && MEM_rd == src) return 2'b10;
      return 2'b00;
   endfunction

   task automatic clear_in();
      ID_rs = '0; ID_rt = '0; EX_rd = '0; MEM_rd = '0;
      ID_uses_rs = 0; ID_uses_rt = 0; ID_Jump = 0;
      EX_RegWrite = 0; EX_MemRead = 0; MEM_RegWrite = 0;
      EX_Branch_EN = 0; ex_busy = 0;
   endtask

   // One pipeline cycle: inputs are already driven just after a negedge.
   task automatic step(input string name);
      logic hold, br, lu, jp;
      logic [1:0] na, nb;
      string kind;
      #1;
      hold = ex_busy;
      br   = !hold && EX_Branch_EN;
      lu   = !hold && !br && EX_MemRead && EX_rd != 0 &&
             ((ID_uses_rs && EX_rd == ID_rs) || (ID_uses_rt && EX_rd == ID_rt));
      jp   = !hold && !br && !lu && ID_Jump;
      kind = hold ? "hold" : br ? "branch" : lu ? "loaduse" : jp ? "jump" : "normal";
      chk({name, ".pc_write"},    PC_Write,    !(hold || lu));
      chk({name, ".ifid_write"},  IF_ID_Write, !(hold || lu));
      chk({name, ".ifid_flush"},  IF_ID_Flush, br || jp);
      chk({name, ".idex_flush"},  ID_EX_Flush, br || lu);
      chk({name, ".freeze"},      Pipe_Freeze, hold);
      if (hold) begin na = m_fwd_a; nb = m_fwd_b; end
      else if (br || lu) begin na = 2'b00; nb = 2'b00; end
      else begin na = want_src(ID_rs, ID_uses_rs); nb = want_src(ID_rt, ID_uses_rt); end
      if (lu   && m_stall  < stat_max) m_stall++;
      if (br   && m_flush  < stat_max) m_flush++;
      if (hold && m_freeze < stat_max) m_freeze++;
      @(posedge clk);
      #1;
      m_fwd_a = na;
      m_fwd_b = nb;
      chk({name, ".fwd_a"}, FwdA, m_fwd_a);
      chk({name, ".fwd_b"}, FwdB, m_fwd_b);
`ifdef HAZARD_STATS_EN
      chk({name, ".stall_cnt"},  stall_cnt,  m_stall);
      chk({name, ".flush_cnt"},  flush_cnt,  m_flush);
      chk({name, ".freeze_cnt"}, freeze_cnt, m_freeze);
`endif
      $display("%0t %-10s %-8s rs=%0d rt=%0d exrd=%0d memrd=%0d -> FwdA=%b FwdB=%b",
               $time, name, kind, ID_rs, ID_rt, EX_rd, MEM_rd, FwdA, FwdB);
      @(negedge clk);
   endtask

   // Reset asserted mid-cycle must override everything immediately.
   task automatic reset_pulse(input string name);
      reset = 1'b0;
      #1;
      chk({name, ".pc_write"},   PC_Write,    1'b0);
      chk({name, ".ifid_write"}, IF_ID_Write, 1'b0);
      chk({name, ".ifid_flush"}, IF_ID_Flush, 1'b1);
      chk({name, ".idex_flush"}, ID_EX_Flush, 1'b1);
      chk({name, ".freeze"},     Pipe_Freeze, 1'b0);
      chk({name, ".fwd_a"},      FwdA,        2'b00);
      chk({name, ".fwd_b"},      FwdB,        2'b00);
      m_fwd_a = 2'b00; m_fwd_b = 2'b00;
      m_stall = 0; m_flush = 0; m_freeze = 0;
      @(posedge clk);
      #1;
      chk({name, ".fwd_a_hold"}, FwdA, 2'b00);
      $display("%0t %-10s reset held", $time, name);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      clear_in();
      ex_busy = 1'b1;   // reset must dominate a busy EX
      reset_pulse("por");
      clear_in();

      // EX producer forwards to rs only.
      EX_RegWrite = 1; EX_rd = 3; ID_rs = 3; ID_uses_rs = 1; ID_rt = 7; ID_uses_rt = 1;
      step("ex_fwd");
      if (FwdA !== 2'b01) $display("FAIL ex_fwd.direct: got %b expected 01", FwdA);

      // EX and MEM both write r3: EX wins on both operands.
      clear_in();
      EX_RegWrite = 1; EX_rd = 3; MEM_RegWrite = 1; MEM_rd = 3;
      ID_rs = 3; ID_rt = 3; ID_uses_rs = 1; ID_uses_rt = 1;
      step("ex_prio");
      chk("ex_prio.direct", {FwdA, FwdB}, 4'b0101);
      EX_rd = 0; MEM_rd = 0; ID_rs = 0; ID_rt = 0;
      step("r0_nofwd");
      chk("r0_nofwd.direct", {FwdA, FwdB}, 4'b0000);

      // Load r5 in EX, consumer reads rt=5: bubble, then forward from WB.
      clear_in();
      EX_MemRead = 1; EX_RegWrite = 1; EX_rd = 5; ID_rt = 5; ID_uses_rt = 1;
      step("ld_use");
      clear_in();
      MEM_RegWrite = 1; MEM_rd = 5; ID_rt = 5; ID_uses_rt = 1;
      step("ld_after");
      chk("ld_after.direct", FwdB, 2'b10);

      // Branch beats load-use and jump.
      clear_in();
      EX_Branch_EN = 1; ID_Jump = 1; EX_MemRead = 1; EX_rd = 4; ID_rs = 4; ID_uses_rs = 1;
      step("br_prio");
      // Jump alone, then jump masked by load-use.
      clear_in();
      ID_Jump = 1; MEM_RegWrite = 1; MEM_rd = 6; ID_rs = 6; ID_uses_rs = 1;
      step("jump");
      EX_MemRead = 1; EX_rd = 6;
      step("jump_lu");

      // Reset in the middle of the STALL cycle, then a normal first cycle.
      clear_in();
      EX_MemRead = 1; EX_rd = 2; ID_rs = 2; ID_uses_rs = 1;
      step("ld_use2");
      reset_pulse("rst_stall");
      clear_in();
      EX_RegWrite = 1; EX_rd = 9; ID_rs = 9; ID_uses_rs = 1;
      step("post_rst");

      // Three busy cycles hold FwdA=01 regardless of other inputs.
      ex_busy = 1; EX_Branch_EN = 1; ID_Jump = 1; EX_rd = 1; ID_rs = 1;
      for (int i = 0; i < 3; i++) step("busy");
      chk("busy.fwd_a_kept", FwdA, 2'b01);
`ifdef HAZARD_STATS_EN
      chk("busy.freeze3", freeze_cnt, 3);
`endif
      clear_in();
      reset_pulse("rst_fwd");

      // Randomized traffic on a small register window to provoke collisions.
      for (int n = 0; n < 300; n++) begin
         ID_rs        = AW'($urandom_range(0, 3));
         ID_rt        = AW'($urandom_range(0, 3));
         EX_rd        = AW'($urandom_range(0, 3));
         MEM_rd       = AW'($urandom_range(0, 3));
         ID_uses_rs   = ($urandom_range(0, 3) != 0);
         ID_uses_rt   = ($urandom_range(0, 1) != 0);
         EX_RegWrite  = ($urandom_range(0, 1) != 0);
         EX_MemRead   = ($urandom_range(0, 3) == 0);
         MEM_RegWrite = ($urandom_range(0, 1) != 0);
         ID_Jump      = ($urandom_range(0, 4) == 0);
         EX_Branch_EN = ($urandom_range(0, 6) == 0);
         ex_busy      = ($urandom_range(0, 4) == 0);
         step("rand");
      end

      // Long freeze drives the freeze counter into saturation.
      clear_in();
      ex_busy = 1;
      for (int i = 0; i < 20; i++) step("sat");
`ifdef HAZARD_STATS_EN
      chk("sat.freeze_max", freeze_cnt, stat_max);
`endif
      clear_in();
      step("tail");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage CPU. It sequences the EX stage and the stages around it.
- Computes operand-forwarding selects in ID and registers them into EX, where they steer DatabusA/DatabusB between the register file, MEM_ALU_out and WB_DatabusC.
- Detects load-use hazards and injects one bubble.
- Flushes wrong-path instructions on a taken branch (EX_Branch_EN) or a jump.
- Freezes the whole pipeline while a multi-cycle EX operation is busy.

Parameters:
REG_AW, 5, register-index width
STAT_W, 16, width of optional statistics counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ID_rs  in  REG_AW  rs index of instruction in ID
ID_rt  in  REG_AW  rt index of instruction in ID
ID_uses_rs  in  1  ID instruction reads rs
ID_uses_rt  in  1  ID instruction reads rt
ID_Jump  in  1  ID instruction is J/JAL/JR/JALR
EX_rd  in  REG_AW  destination of instruction in EX
EX_RegWrite  in  1  EX instruction writes register
EX_MemRead  in  1  EX instruction is a load
MEM_rd  in  REG_AW  destination of instruction in MEM
MEM_RegWrite  in  1  MEM instruction writes register
EX_Branch_EN  in  1  branch in EX is taken
ex_busy  in  1  multi-cycle EX operation in progress
PC_Write  out  1  PC update enable
IF_ID_Write  out  1  IF/ID register load enable
IF_ID_Flush  out  1  load NOP into IF/ID
ID_EX_Flush  out  1  load bubble into ID/EX
Pipe_Freeze  out  1  hold ID/EX, EX/MEM and MEM/WB registers
FwdA  out  2  EX operand-A select, registered
FwdB  out  2  EX operand-B select, registered

Behaviour:
- Forward encoding: 00 register file, 01 MEM_ALU_out, 10 WB_DatabusC.
- Next-select for A: 01 if EX_RegWrite & EX_rd!=0 & EX_rd==ID_rs & ID_uses_rs; else 10 if MEM_RegWrite & MEM_rd!=0 & MEM_rd==ID_rs & ID_uses_rs; else 00. B is identical using rt/ID_uses_rt. The EX match has priority over the MEM match. Register 0 is never forwarded.
- FSM states: RUN, HOLD, STALL. A 2-bit state register, reset to RUN.
- HOLD: entered whenever ex_busy=1, from any state.
  - Pipe_Freeze=1, PC_Write=0, IF_ID_Write=0, both flushes=0.
  - FwdA/FwdB hold their value.
  - EX_Branch_EN, ID_Jump and hazard detection are ignored.
  - When ex_busy drops, evaluate as RUN in that same cycle.
- Load-use (state RUN/STALL, ex_busy=0, EX_Branch_EN=0): condition is EX_MemRead & EX_rd!=0 & (rs match | rt match).
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1.
  - Fwd registers load 00.
  - Next state STALL.
- STALL lasts exactly one cycle. The load is now in MEM, the bubble is in EX, and the dependent instruction is re-evaluated normally; its select resolves to 10. Next state RUN.
- Taken branch (EX_Branch_EN=1, ex_busy=0):
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1 (PC loads ConBA), IF_ID_Write=1.
  - Fwd registers load 00.
  - Has priority over load-use and jump in the same cycle.
- Jump (ID_Jump=1, no branch, no load-use): IF_ID_Flush=1, PC_Write=1. ID/EX loads normally. If load-use and jump coincide, the load-use stall wins and the jump is re-evaluated next cycle.
- Normal cycle: PC_Write=1, IF_ID_Write=1, flushes=0, Pipe_Freeze=0; Fwd registers load next-select.
- Latency: all control outputs except FwdA/FwdB are combinational from inputs and state, so they take effect in the same cycle. FwdA/FwdB update at the clock edge, aligned with ID/EX.
- Reset (reset=0, takes effect immediately and mid-operation):
  - state=RUN, FwdA=FwdB=00.
  - PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, Pipe_Freeze=0.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, add three outputs, each STAT_W wide and reset to 0: stall_cnt, flush_cnt, freeze_cnt.
  - stall_cnt: +1 per load-use cycle.
  - flush_cnt: +1 per taken-branch cycle.
  - freeze_cnt: +1 per HOLD cycle.
  - All three saturate at all-ones and do not wrap.
- When undefined, the ports and logic are absent; control behaviour is identical.

Test Plan:
- EX: add r3, EX_RegWrite=1, EX_rd=3; ID reads rs=3 -> after the edge FwdA=01, FwdB=00, no stall.
- EX_rd=3 and MEM_rd=3 both writing; ID rs=rt=3 -> FwdA=FwdB=01 (EX priority). Repeat with rd=0 -> FwdA=FwdB=00.
- Load r5 in EX (EX_MemRead=1, EX_rd=5); ID rt=5 used ->
  - Cycle 0: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, state STALL.
  - Cycle 1: normal, FwdB=10 after the edge, state RUN.
- EX_Branch_EN=1 coincident with a load-use hazard and ID_Jump=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, Fwd=00; no stall.
- ex_busy=1 for 3 cycles with FwdA=01 -> Pipe_Freeze=1, PC_Write=0, FwdA stays 01 for all 3 cycles. With HAZARD_STATS_EN, freeze_cnt=3.
- Assert reset low mid-STALL -> state RUN, Fwd=00, both flushes=1 immediately. After release, the first cycle is normal.
